// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction path.
// - INSTR_W  : instruction word width in bits.
// - NOP_WORD : the encoding of a no-operation instruction.
// - loader_state_e : state encoding of the boot-time instruction RAM loader.
// - loader_is_timed / loader_is_busy : state classification helpers.
// -----------------------------------------------------------------------------
package isa_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'b0000_1000_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_e;

  // States that are waiting on the UART and therefore subject to the
  // inter-byte timeout.
  function automatic logic loader_is_timed(input loader_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DAT_LO) || (s == DAT_HI);
  endfunction

  // States in which a load is in progress and the CPU must be stalled.
  function automatic logic loader_is_busy(input loader_state_e s);
    return (s != IDLE) && (s != DONE) && (s != ERR);
  endfunction

endpackage

// File: rtl/inst_ram_loader_timeout_ctr.sv
// -----------------------------------------------------------------------------
// loader_timeout_ctr
// Down-counter used as an inter-byte watchdog.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset (counter cleared to 0)
//   clr_i      in   reload the counter with LOAD (has priority over en_i)
//   en_i       in   count down by one per cycle; counter sticks at zero
//   expired_o  out  counter is at zero while enabled
// With LOAD = N-1, expired_o rises N-1 enabled cycles after the last clear, so
// a consumer that acts on expired_o at the following edge acts N cycles after
// the clear.
// -----------------------------------------------------------------------------
module loader_timeout_ctr #(
  parameter int unsigned      W    = 24,
  parameter logic [W-1:0]     LOAD = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/inst_ram_loader.sv
// -----------------------------------------------------------------------------
// inst_ram_loader
// Boot-time writer for the instruction RAM. Receives a length-prefixed,
// little-endian byte stream from the UART receiver (2 length bytes, then 2
// bytes per instruction word), writes each word through a req/ack RAM port
// and holds the CPU stalled while a load is in progress.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-low reset
//   start          in   one-cycle pulse; begins a load from IDLE/DONE/ERR
//   rx_data[7:0]   in   received UART byte
//   rx_valid       in   one-cycle strobe qualifying rx_data
//   ram_addr[15:0] out  word address of the write
//   ram_wdata[15:0]out  instruction word being written
//   ram_we         out  write request, held until ram_ack
//   ram_ack        in   RAM accepted the write (sampled while ram_we=1)
//   cpu_hold       out  stall the CPU/PC while loading
//   done           out  load completed, until the next start
//   err            out  load aborted, until the next start
//   words_written  out  words acknowledged in the current load
// -----------------------------------------------------------------------------
module inst_ram_loader
  import isa_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024,
  parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [15:0]        ram_addr,
  output logic [INSTR_W-1:0] ram_wdata,
  output logic               ram_we,
  input  logic               ram_ack,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [15:0]        words_written
);

  loader_state_e      state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         lo_q, lo_d;
  logic [15:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [15:0]        words_q, words_d;

  logic               tmo_clr;
  logic               tmo_en;
  logic               tmo_expired;
  logic [15:0]        new_len;
  logic [15:0]        words_inc;

  assign new_len   = {rx_data, len_q[7:0]};
  assign words_inc = words_q + 16'd1;

  // ---------------------------------------------------------------------------
  // Inter-byte watchdog: restarted on every byte and on every state change,
  // counts only while waiting on the UART (frozen during WRITE).
  // ---------------------------------------------------------------------------
  assign tmo_en  = loader_is_timed(state_q);
  assign tmo_clr = rx_valid || (state_d != state_q);

  loader_timeout_ctr #(
    .W    (24),
    .LOAD (TIMEOUT - 24'd1)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // A byte arriving together with start is deliberately dropped.
        if (start) begin
          state_d = LEN_LO;
          words_d = 16'd0;
        end
      end

      LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end

      LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          if (new_len == 16'd0) begin
            state_d = DONE;
          end else if (new_len > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DAT_LO;
          end
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end

      DAT_LO: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          state_d = DAT_HI;
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end

      DAT_HI: begin
        if (rx_valid) begin
          wdata_d = {rx_data, lo_q};
          addr_d  = BASE_ADDR + words_q;  // wraps modulo 2^16
          state_d = WRITE;
        end else if (tmo_expired) begin
          state_d = ERR;
        end
      end

      WRITE: begin
        // A byte during a write means the RAM is too slow for the link;
        // the overrun wins over a coincident ack and the word is not counted.
        if (rx_valid) begin
          state_d = ERR;
        end else if (ram_ack) begin
          words_d = words_inc;
          state_d = (words_inc == len_q) ? DONE : DAT_LO;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      lo_q    <= 8'd0;
      addr_q  <= 16'd0;
      wdata_q <= '0;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registered state so reset clears them at once.
  // ---------------------------------------------------------------------------
  assign ram_we        = (state_q == WRITE);
  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign cpu_hold      = loader_is_busy(state_q);
  assign done          = (state_q == DONE);
  assign err           = (state_q == ERR);
  assign words_written = words_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_ram_loader
// Directed stimulus for inst_ram_loader. Expected RAM writes are queued when
// the data bytes are issued; a negedge monitor models the RAM ack and pops and
// compares each accepted write. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_inst_ram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_ack;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  int errors;
  int checks;
  int ack_delay;
  int we_cycles;

  inst_ram_loader #(
    .BASE_ADDR (16'h0000),
    .MAX_WORDS (16'd1024),
    .TIMEOUT   (24'd100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_ack       (ram_ack),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // RAM model and scoreboard monitor. Runs on the falling edge, where inputs
  // driven #1 after the rising edge are stable.
  task automatic sb_monitor();
    int  we_run;
    wr_t e;
    we_run = 0;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        we_run++;
        we_cycles++;
      end else begin
        we_run = 0;
      end
      ram_ack = (ack_delay == 0) ? 1'b1 : (ram_we && (we_run >= ack_delay));
      if (ram_we && ram_ack && !rx_valid && rst) begin
        $display("write addr=%04h data=%04h", ram_addr, ram_wdata);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%04h data=%04h expected none", ram_addr, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {16'd0, ram_addr}, {16'd0, e.addr});
          check("wr_data", {16'd0, ram_wdata}, {16'd0, e.data});
        end
      end
    end
  endtask

  task automatic watchdog();
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    int w0;
    int n;
    errors    = 0;
    checks    = 0;
    ack_delay = 0;
    we_cycles = 0;
    ram_ack   = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    fork
      sb_monitor();
      watchdog();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_we",   {31'd0, ram_we},   32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_words",    {16'd0, words_written}, 32'd0);
    check("rst_addr",     {16'd0, ram_addr},  32'd0);
    check("rst_wdata",    {16'd0, ram_wdata}, 32'd0);
    rst = 1'b1;

    // Basic load: 02 00 BF 69 20 31, ack tied high
    push_wr(16'h0000, 16'h69BF);
    push_wr(16'h0001, 16'h3120);
    pulse_start();
    check("basic_hold_start", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hBF);
    send_byte(8'h69);
    check("basic_we_latency1", {31'd0, ram_we}, 32'd1);
    send_byte(8'h20);
    send_byte(8'h31);
    check("basic_we_latency2", {31'd0, ram_we}, 32'd1);
    check("basic_done_early",  {31'd0, done},   32'd0);
    @(posedge clk); #1;
    check("basic_done",  {31'd0, done},     32'd1);
    check("basic_hold",  {31'd0, cpu_hold}, 32'd0);
    check("basic_words", {16'd0, words_written}, 32'd2);
    repeat (2) @(posedge clk);
    #1 check("basic_sb_empty", exp_q.size(), 32'd0);

    // Zero-length load, restarting from DONE
    pulse_start();
    check("zero_done_cleared", {31'd0, done},     32'd0);
    check("zero_words_clr",    {16'd0, words_written}, 32'd0);
    check("zero_hold",         {31'd0, cpu_hold}, 32'd1);
    w0 = we_cycles;
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done",  {31'd0, done}, 32'd1);
    check("zero_words", {16'd0, words_written}, 32'd0);
    check("zero_no_we", we_cycles - w0, 32'd0);

    // Length too large: 0x0401
    pulse_start();
    w0 = we_cycles;
    send_byte(8'h01);
    send_byte(8'h04);
    check("big_err",   {31'd0, err},      32'd1);
    check("big_hold",  {31'd0, cpu_hold}, 32'd0);
    check("big_no_we", we_cycles - w0,    32'd0);

    // Length exactly MAX_WORDS is accepted, then abandoned by timeout
    pulse_start();
    check("max_err_cleared", {31'd0, err}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h04);
    check("max_accept_err",  {31'd0, err},      32'd0);
    check("max_accept_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (105) @(posedge clk);
    #1 check("max_timeout_err", {31'd0, err}, 32'd1);

    // Overrun under slow RAM
    ack_delay = 5;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    push_wr(16'h0000, 16'h55AA);
    send_byte(8'hAA);
    send_byte(8'h55);
    n = 0;
    while (ram_we && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovr_ack_wait_bounded", {31'd0, (n < 20)}, 32'd1);
    check("ovr_words_first", {16'd0, words_written}, 32'd1);
    send_byte(8'h34);
    send_byte(8'h12);
    check("ovr_we_high", {31'd0, ram_we}, 32'd1);
    check("ovr_wdata",   {16'd0, ram_wdata}, 32'h1234);
    check("ovr_addr",    {16'd0, ram_addr},  32'h0001);
    send_byte(8'hEE);
    check("ovr_err",   {31'd0, err},    32'd1);
    check("ovr_we",    {31'd0, ram_we}, 32'd0);
    check("ovr_words", {16'd0, words_written}, 32'd1);
    check("ovr_sb_empty", exp_q.size(), 32'd0);

    // Timeout: one length byte then silence
    ack_delay = 0;
    pulse_start();
    send_byte(8'h05);
    repeat (99) @(posedge clk);
    #1;
    check("tmo_err_early", {31'd0, err}, 32'd0);
    check("tmo_hold_early", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    check("tmo_err",  {31'd0, err},      32'd1);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd0);

    // Asynchronous reset while a write is pending
    ack_delay = 50;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check("ar_we_before", {31'd0, ram_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_we",    {31'd0, ram_we},   32'd0);
    check("ar_addr",  {16'd0, ram_addr},  32'd0);
    check("ar_wdata", {16'd0, ram_wdata}, 32'd0);
    check("ar_hold",  {31'd0, cpu_hold}, 32'd0);
    check("ar_done",  {31'd0, done},     32'd0);
    check("ar_err",   {31'd0, err},      32'd0);
    check("ar_words", {16'd0, words_written}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ack_delay = 0;
    push_wr(16'h0000, 16'h5678);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    @(posedge clk); #1;
    check("ar_reload_done",  {31'd0, done}, 32'd1);
    check("ar_reload_words", {16'd0, words_written}, 32'd1);
    repeat (2) @(posedge clk);
    #1 check("ar_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
